// File: rtl/updi_cmd_sequencer.sv
// updi_cmd_sequencer: sends SYNC+instruction, checks echo, forwards response; UPDI_SEQ_AUTO_BREAK_EN adds double-break recovery
module updi_cmd_sequencer #(
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_tx_data,
  input  logic [1:0]  cmd_tx_len,
  input  logic [1:0]  cmd_rx_len,
  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  uart_tx_fifo_data_in,
  output logic        uart_tx_fifo_wr_en,
  input  logic        uart_tx_fifo_full,
  input  logic [7:0]  uart_rx_fifo_data_out,
  output logic        uart_rx_fifo_rd_en,
  input  logic        uart_rx_fifo_empty,
  input  logic        phy_error,
  output logic        double_break_start,
  input  logic        double_break_busy,
  input  logic        double_break_done
);
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CLKS - 1);
  typedef enum logic [2:0] {IDLE, SEND, ECHO, RESP, FIN
`ifdef UPDI_SEQ_AUTO_BREAK_EN
    , BREAK
`endif
  } state_t;
  state_t state_q, state_d;
  logic [31:0] tx_q, tx_d;
  logic [1:0] tx_len_q, tx_len_d, rx_len_q, rx_len_d, err_q, err_d, fail_code;
  logic [2:0] idx_q, idx_d, echo_last;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, brk_q, brk_d, pop, unused_in;
  logic [39:0] frame_sh;
  assign unused_in = double_break_busy ^ double_break_done;
  // frame byte 0 is SYNC, byte k is instruction byte k-1; used for both TX and echo compare
  assign frame_sh = {tx_q, 8'h55} >> {idx_q, 3'b000};
  assign echo_last = {1'b0, tx_len_q} + 3'd1;
  assign cmd_ready = state_q == IDLE;
  assign uart_tx_fifo_data_in = frame_sh[7:0];
  assign uart_tx_fifo_wr_en = state_q == SEND && !uart_tx_fifo_full;
  assign pop = (state_q == ECHO || state_q == RESP) && !uart_rx_fifo_empty;
  assign uart_rx_fifo_rd_en = pop;
  assign rsp_valid = pop && state_q == RESP && !phy_error;
  assign rsp_data = rsp_valid ? uart_rx_fifo_data_out : 8'h00;
  assign done = done_q;
  assign err_code = err_q;
  assign error = done_q && err_q != 2'b00;
  assign double_break_start = brk_q;
  assign fail_code = phy_error ? 2'b11
                   : (pop && state_q == ECHO && uart_rx_fifo_data_out != frame_sh[7:0]) ? 2'b01
                   : (!pop && cnt_q == TLAST) ? 2'b10 : 2'b00;
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    tx_len_d = tx_len_q;
    rx_len_d = rx_len_q;
    err_d = err_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SEND;
        tx_d = cmd_tx_data;
        tx_len_d = cmd_tx_len;
        rx_len_d = cmd_rx_len;
        err_d = 2'b00;
        idx_d = '0;
      end
      SEND: if (!uart_tx_fifo_full) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == echo_last) begin
          state_d = ECHO;
          idx_d = '0;
          cnt_d = '0;
        end
      end
      ECHO, RESP: begin
        cnt_d = pop ? '0 : cnt_q + 1'b1;
        if (fail_code != 2'b00) begin
          err_d = fail_code;
`ifdef UPDI_SEQ_AUTO_BREAK_EN
          state_d = BREAK;
`else
          state_d = FIN;
`endif
        end else if (pop) begin
          idx_d = idx_q + 3'd1;
          if (state_q == ECHO && idx_q == echo_last) begin
            idx_d = '0;
            state_d = rx_len_q == 2'd0 ? FIN : RESP;
          end
          if (state_q == RESP && idx_q + 3'd1 == {1'b0, rx_len_q}) state_d = FIN;
        end
      end
`ifdef UPDI_SEQ_AUTO_BREAK_EN
      BREAK: if (double_break_done && !brk_q) state_d = FIN;
`endif
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = state_d == FIN;
`ifdef UPDI_SEQ_AUTO_BREAK_EN
    brk_d = state_d == BREAK && state_q != BREAK;
`else
    brk_d = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q <= '0;
      tx_len_q <= '0;
      rx_len_q <= '0;
      err_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      tx_len_q <= tx_len_d;
      rx_len_q <= rx_len_d;
      err_q <= err_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      brk_q <= brk_d;
    end
  end
endmodule

// File: tb/tb_updi_cmd_sequencer.sv
// tb_updi_cmd_sequencer: directed and randomized commands against a byte-stream reference model
module tb_updi_cmd_sequencer;
`ifdef UPDI_SEQ_AUTO_BREAK_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, full = 1'b0, rx_clr = 1'b0;
  logic [31:0] cmd_tx_data = '0;
  logic [1:0] cmd_tx_len = '0, cmd_rx_len = '0, err_code;
  logic cmd_ready, rsp_valid, done, error, wr_en, rd_en, empty, phy_error, brk_start, brk_busy;
  logic brk_d1 = 1'b0, brk_done = 1'b0;
  logic [7:0] rsp_data, tx_data, rx_data;
  logic [7:0] rx_mem [16];
  logic [7:0] stim [8];
  logic [7:0] tx_log [$];
  logic [7:0] rsp_log [$];
  int rx_lim = 0, rd_ptr = 0, phy_at = -1;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, first_wr = 0, last_wr = 0, done_cyc = 0, done_n = 0, brk_n = 0;
  logic done_err = 1'b0;
  logic [1:0] done_code = '0;

  always #5 clk = ~clk;

  updi_cmd_sequencer #(.TIMEOUT_CLKS(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tx_data(cmd_tx_data), .cmd_tx_len(cmd_tx_len), .cmd_rx_len(cmd_rx_len),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .done(done), .error(error), .err_code(err_code),
    .uart_tx_fifo_data_in(tx_data), .uart_tx_fifo_wr_en(wr_en), .uart_tx_fifo_full(full),
    .uart_rx_fifo_data_out(rx_data), .uart_rx_fifo_rd_en(rd_en), .uart_rx_fifo_empty(empty),
    .phy_error(phy_error), .double_break_start(brk_start), .double_break_busy(brk_busy),
    .double_break_done(brk_done)
  );

  assign empty = rd_ptr >= rx_lim;
  assign rx_data = rx_mem[rd_ptr[3:0]];
  assign phy_error = rd_ptr == phy_at;
  assign brk_busy = brk_d1;

  always @(posedge clk) begin
    rd_ptr <= rx_clr ? 0 : rd_ptr + int'(rd_en);
    brk_d1 <= brk_start;
    brk_done <= brk_d1;
  end

  always @(negedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready && !rst) acc_cyc = cyc;
    if (wr_en) begin
      if (tx_log.size() == 0) first_wr = cyc;
      last_wr = cyc;
      tx_log.push_back(tx_data);
    end
    if (rsp_valid) rsp_log.push_back(rsp_data);
    if (brk_start) brk_n++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_err = error;
      done_code = err_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_stim(input logic [63:0] v);
    for (int i = 0; i < 8; i++) stim[i] = v[8*i +: 8];
  endtask

  task automatic run(input logic [31:0] d, input logic [1:0] txl, input logic [1:0] rxl,
                     input int n_avail, input int phy, input logic [31:0] pat, input bit junk);
    logic [7:0] e [$];
    logic [7:0] exp_rsp [$];
    int exp_err, exp_pops, ne;
    exp_err = 0;
    exp_pops = 0;
    e.push_back(8'h55);
    for (int i = 0; i <= int'(txl); i++) e.push_back(d[8*i +: 8]);
    ne = e.size();
    for (int i = 0; i < ne + int'(rxl); i++) begin
      if (i >= n_avail) begin exp_err = 2; break; end
      exp_pops++;
      if (i == phy) begin exp_err = 3; break; end
      if (i < ne && stim[i] != e[i]) begin exp_err = 1; break; end
      if (i >= ne) exp_rsp.push_back(stim[i]);
    end
    @(posedge clk); #1;
    rx_clr = 1'b1;
    @(posedge clk); #1;
    rx_clr = 1'b0;
    for (int i = 0; i < 8; i++) rx_mem[i] = stim[i];
    rx_lim = n_avail;
    phy_at = phy;
    tx_log.delete();
    rsp_log.delete();
    done_n = 0;
    brk_n = 0;
    cmd_tx_data = d;
    cmd_tx_len = txl;
    cmd_rx_len = rxl;
    cmd_valid = 1'b1;
    check("ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = junk;
    cmd_tx_data = $urandom;
    for (int j = 0; j < 300 && done_n == 0; j++) begin
      full = j < 32 ? pat[j] : 1'b0;
      @(posedge clk); #1;
    end
    full = 1'b0;
    cmd_valid = 1'b0;
    phy_at = -1;
    check("done_once", done_n, 1);
    check("err_code", done_code, exp_err);
    check("error", done_err, exp_err != 0);
    check("tx_count", tx_log.size(), ne);
    for (int i = 0; i < ne && i < tx_log.size(); i++) check("tx_byte", tx_log[i], e[i]);
    check("rsp_count", rsp_log.size(), exp_rsp.size());
    for (int i = 0; i < exp_rsp.size() && i < rsp_log.size(); i++) check("rsp_byte", rsp_log[i], exp_rsp[i]);
    if (exp_err != 3) check("pops", rd_ptr, exp_pops);
    if (!pat[0]) check("lat_wr", first_wr - acc_cyc, 1);
    if (!BRK || exp_err == 0) check("lat_done", done_cyc - last_wr - 1, exp_pops + (exp_err == 2 ? 16 : 0));
    check("brk_pulses", brk_n, BRK && exp_err != 0);
    check("done_pulse", done, 0);
    check("err_hold", err_code, exp_err);
  endtask

  initial begin
    logic [31:0] d, pat;
    logic [1:0] txl, rxl;
    int total, n, phy, pos;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_brk", brk_start, 0);
    rst = 1'b0;
    set_stim(64'h308055);
    run(32'h80, 2'd0, 2'd1, 3, -1, 32'h0, 1'b0);
    set_stim(64'h08C355);
    run(32'h08C2, 2'd1, 2'd0, 3, -1, 32'h0, 1'b1);
    run(32'h80, 2'd0, 2'd1, 0, -1, 32'h0, 1'b0);
    set_stim(64'hD4C3B2A155);
    run(32'hD4C3B2A1, 2'd3, 2'd0, 5, -1, 32'h3E, 1'b0);
    set_stim(64'h08C355);
    run(32'h08C2, 2'd1, 2'd0, 3, 1, 32'h0, 1'b0);
    @(posedge clk); #1;
    tx_log.delete();
    cmd_tx_data = 32'h44332211;
    cmd_tx_len = 2'd3;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    full = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    full = 1'b0;
    check("mid_rst_ready", cmd_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_writes", tx_log.size(), 1);
    check("mid_rst_sync", tx_log[0], 8'h55);
    for (int r = 0; r < 40; r++) begin
      d = $urandom;
      txl = 2'($urandom_range(0, 3));
      rxl = 2'($urandom_range(0, 3));
      set_stim({$urandom, $urandom});
      stim[0] = 8'h55;
      for (int i = 0; i <= int'(txl); i++) stim[i+1] = d[8*i +: 8];
      total = int'(txl) + 2 + int'(rxl);
      n = total;
      phy = -1;
      case ($urandom_range(0, 3))
        1: begin
          pos = $urandom_range(0, int'(txl) + 1);
          stim[pos] = stim[pos] ^ 8'($urandom_range(1, 255));
        end
        2: n = $urandom_range(0, total - 1);
        3: phy = $urandom_range(0, total - 1);
        default: ;
      endcase
      pat = $urandom & $urandom;
      run(d, txl, rxl, n, phy, pat, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
